// File: rtl/write_buffer_ctrl.sv
// rtl/write_buffer_ctrl.sv - cache-to-memory write buffer with refill reads; optional WB_MATCH_DRAIN_EN
module write_buffer_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [BLOCK_W-1:0] rd_data,
  output logic               rd_done,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BLK_W = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, READ} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_d [DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [DEPTH];
  logic [DATA_W-1:0]   fifo_data_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                rd_pend_q, rd_pend_d;
  logic [BLK_W-1:0]    rd_blk_q, rd_blk_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BLOCK_W-1:0]  rd_data_q, rd_data_d;
  logic                rd_done_q, rd_done_d;

  logic                push, pop, drain_needed;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic                unused_rd_offset;

  // Refills are whole blocks, so the word/byte offset of rd_addr carries no information.
  assign unused_rd_offset = ^rd_addr[3:0];

  assign wr_ready  = (count_q < CNT_W'(DEPTH)) && !rd_pend_q;
  assign buf_empty = (count_q == '0);
  assign push      = wr_valid && wr_ready;
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_done   = rd_done_q;

`ifdef WB_MATCH_DRAIN_EN
  logic any_match;

  // Scan the valid entries for any write that lands in the block being refilled.
  always_comb begin
    any_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) &&
          (fifo_addr_q[rd_ptr_q + PTR_W'(i)][ADDR_W-1:4] == rd_blk_q)) begin
        any_match = 1'b1;
      end
    end
  end

  assign drain_needed = any_match;
`else
  assign drain_needed = (count_q != '0);
`endif

  // Next-state, FIFO bookkeeping and registered memory-interface outputs.
  always_comb begin
    state_d     = state_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_pend_d   = rd_pend_q;
    rd_blk_d    = rd_blk_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    rd_done_d   = 1'b0;
    pop         = 1'b0;

    if (push) begin
      fifo_addr_d[wr_ptr_q] = wr_addr;
      fifo_data_d[wr_ptr_q] = wr_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end

    // A refill already pending swallows further rd_req pulses.
    if (rd_req && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_blk_d  = rd_addr[ADDR_W-1:4];
    end

    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = DRAIN;
        end else if (count_q != '0) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end
      end
      WRITE: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            pop       = 1'b1;
            mem_req_d = 1'b0;
            if (rd_pend_d)                 state_d = DRAIN;
            else if (count_q > CNT_W'(1))  state_d = WRITE;
            else                           state_d = IDLE;
          end
        end else if (rd_pend_d) begin
          state_d = DRAIN;
        end else if (count_q != '0) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            pop       = 1'b1;
            mem_req_d = 1'b0;
          end
        end else if (drain_needed) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end else begin
          state_d    = READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {rd_blk_q, 4'b0000};
        end
      end
      READ: begin
        if (mem_req_q && mem_ack) begin
          mem_req_d = 1'b0;
          rd_data_d = mem_rdata;
          rd_done_d = 1'b1;
          rd_pend_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control and interface registers; reset abandons any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      rd_blk_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      rd_blk_q    <= rd_blk_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_done_q   <= rd_done_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_write_buffer_ctrl.sv
// tb/tb_write_buffer_ctrl.sv - directed self-checking bench for write_buffer_ctrl
module tb_write_buffer_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [9:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         rd_req = 1'b0;
  logic [9:0]   rd_addr = '0;
  logic [127:0] rd_data;
  logic         rd_done;
  logic         mem_req;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         buf_empty;

  int checks = 0;
  int failures = 0;

  bit auto_ack = 1'b0;
  int ack_lat = 1;
  int wait_cnt = 0;
  int rd_done_cnt = 0;

  logic        log_we [$];
  logic [9:0]  log_addr [$];
  logic [31:0] log_data [$];

  write_buffer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  // Memory model: ack a held request after ack_lat cycles, changing just after the edge.
  always @(posedge clk) begin
    #2;
    if (!rst_n || mem_ack) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (auto_ack && mem_req) begin
      wait_cnt++;
      if (wait_cnt >= ack_lat) mem_ack = 1'b1;
    end else begin
      wait_cnt = 0;
    end
  end

  // Record every completed memory transaction in order.
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  always @(negedge clk) if (rd_done) rd_done_cnt++;

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    wr_addr = a;
    wr_data = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (wr_ready) begin
        @(negedge clk);
        wr_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input string nm);
    for (int i = 0; i < 400 && log_addr.size() < n; i++) @(negedge clk);
    checks++;
    if (log_addr.size() < n) begin
      failures++;
      $display("FAIL %s_timeout got=%0d exp=%0d", nm, log_addr.size(), n);
    end
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 400 && !(buf_empty && !mem_req && !rd_done); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 10'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (rd_data !== 128'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    checks++; if (rd_done !== 1'b0) begin failures++; $display("FAIL rst_rd_done got=%b exp=0", rd_done); end
    checks++; if (buf_empty !== 1'b1) begin failures++; $display("FAIL rst_buf_empty got=%b exp=1", buf_empty); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_single_write();
    bit ok;
    clear_log();
    ack_lat = 3;
    auto_ack = 1'b1;
    push_wr(10'h040, 32'h1111_1111, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL w1_accept got=%b exp=1", ok); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL w1_req_early got=%b exp=0", mem_req); end
    checks++; if (buf_empty !== 1'b0) begin failures++; $display("FAIL w1_not_empty got=%b exp=0", buf_empty); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL w1_req_latency got=%b exp=1", mem_req); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL w1_we got=%b exp=1", mem_we); end
    checks++; if (mem_addr !== 10'h040) begin failures++; $display("FAIL w1_addr got=%h exp=040", mem_addr); end
    checks++; if (mem_wdata !== 32'h1111_1111) begin failures++; $display("FAIL w1_wdata got=%h exp=11111111", mem_wdata); end
    wait_log(1, "w1");
    repeat (2) @(negedge clk);
    checks++; if (log_addr.size() !== 1) begin failures++; $display("FAIL w1_count got=%0d exp=1", log_addr.size()); end
    checks++; if (log_we[0] !== 1'b1 || log_addr[0] !== 10'h040 || log_data[0] !== 32'h1111_1111) begin
      failures++; $display("FAIL w1_log got=%b/%h/%h exp=1/040/11111111", log_we[0], log_addr[0], log_data[0]);
    end
    checks++; if (buf_empty !== 1'b1) begin failures++; $display("FAIL w1_empty_after got=%b exp=1", buf_empty); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL w1_req_after got=%b exp=0", mem_req); end
  endtask

  task automatic test_full();
    bit ok;
    bit stalled;
    logic [9:0] exp_a [5];
    exp_a = '{10'h100, 10'h104, 10'h108, 10'h10C, 10'h110};
    clear_log();
    auto_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_wr(exp_a[i], 32'hA000_0000 + 32'(i), ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL full_accept%0d got=%b exp=1", i, ok); end
    end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", wr_ready); end
    wr_addr = exp_a[4];
    wr_data = 32'hA000_0004;
    wr_valid = 1'b1;
    stalled = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (wr_ready !== 1'b0 || log_addr.size() != 0) stalled = 1'b0;
    end
    checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL full_hold got=%b exp=1", stalled); end
    ack_lat = 2;
    auto_ack = 1'b1;
    push_wr(exp_a[4], 32'hA000_0004, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL full_fifth got=%b exp=1", ok); end
    checks++; if (log_addr.size() < 1) begin failures++; $display("FAIL full_fifth_after_ack got=%0d exp>=1", log_addr.size()); end
    wait_log(5, "full");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_addr[i] !== exp_a[i] || log_data[i] !== 32'hA000_0000 + 32'(i) || log_we[i] !== 1'b1) begin
        failures++; $display("FAIL full_order%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], exp_a[i], 32'hA000_0000 + 32'(i));
      end
    end
    wait_quiet();
  endtask

  task automatic test_drain_before_read();
    bit ok;
    int rd0;
    logic       exp_we [3];
    logic [9:0] exp_a [3];
`ifdef WB_MATCH_DRAIN_EN
    exp_we = '{1'b1, 1'b0, 1'b1};
    exp_a  = '{10'h040, 10'h040, 10'h080};
`else
    exp_we = '{1'b1, 1'b1, 1'b0};
    exp_a  = '{10'h040, 10'h080, 10'h040};
`endif
    clear_log();
    rd0 = rd_done_cnt;
    auto_ack = 1'b0;
    mem_rdata = {4{32'hC0DE_0001}};
    push_wr(10'h040, 32'h2222_0040, ok);
    push_wr(10'h080, 32'h2222_0080, ok);
    rd_addr = 10'h044;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL drain_ready_blocked got=%b exp=0", wr_ready); end
    ack_lat = 2;
    auto_ack = 1'b1;
    wait_log(3, "drain");
    wait_quiet();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_we[i] !== exp_we[i] || log_addr[i] !== exp_a[i]) begin
        failures++; $display("FAIL drain_order%0d got=%b/%h exp=%b/%h", i, log_we[i], log_addr[i], exp_we[i], exp_a[i]);
      end
    end
    checks++; if (rd_done_cnt - rd0 !== 1) begin failures++; $display("FAIL drain_rd_done got=%0d exp=1", rd_done_cnt - rd0); end
    checks++; if (rd_data !== {4{32'hC0DE_0001}}) begin failures++; $display("FAIL drain_rd_data got=%h exp=%h", rd_data, {4{32'hC0DE_0001}}); end
  endtask

  task automatic test_refill_empty();
    clear_log();
    ack_lat = 1;
    auto_ack = 1'b1;
    mem_rdata = {16{8'hA5}};
    rd_addr = 10'h04C;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rf_req_c1 got=%b exp=0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rf_req_c2 got=%b exp=1", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rf_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 10'h040) begin failures++; $display("FAIL rf_addr got=%h exp=040", mem_addr); end
    checks++; if (rd_done !== 1'b0) begin failures++; $display("FAIL rf_done_early got=%b exp=0", rd_done); end
    @(negedge clk);
    checks++; if (rd_done !== 1'b1) begin failures++; $display("FAIL rf_done got=%b exp=1", rd_done); end
    checks++; if (rd_data !== {16{8'hA5}}) begin failures++; $display("FAIL rf_data got=%h exp=%h", rd_data, {16{8'hA5}}); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rf_req_drop got=%b exp=0", mem_req); end
    @(negedge clk);
    checks++; if (rd_done !== 1'b0) begin failures++; $display("FAIL rf_done_pulse got=%b exp=0", rd_done); end
    wait_quiet();
  endtask

  task automatic test_same_cycle();
    int rd0;
    clear_log();
    rd0 = rd_done_cnt;
    ack_lat = 1;
    auto_ack = 1'b1;
    mem_rdata = {4{32'h5A5A_0048}};
    wr_addr = 10'h048;
    wr_data = 32'h4848_4848;
    wr_valid = 1'b1;
    rd_addr = 10'h040;
    rd_req = 1'b1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL sc_ready got=%b exp=1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
    rd_req = 1'b0;
    wait_log(2, "sc");
    wait_quiet();
    checks++; if (log_we[0] !== 1'b1 || log_addr[0] !== 10'h048 || log_data[0] !== 32'h4848_4848) begin
      failures++; $display("FAIL sc_first got=%b/%h/%h exp=1/048/48484848", log_we[0], log_addr[0], log_data[0]);
    end
    checks++; if (log_we[1] !== 1'b0 || log_addr[1] !== 10'h040) begin
      failures++; $display("FAIL sc_second got=%b/%h exp=0/040", log_we[1], log_addr[1]);
    end
    checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL sc_count got=%0d exp=2", log_addr.size()); end
    checks++; if (rd_done_cnt - rd0 !== 1) begin failures++; $display("FAIL sc_rd_done got=%0d exp=1", rd_done_cnt - rd0); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit quiet;
    clear_log();
    auto_ack = 1'b0;
    push_wr(10'h200, 32'h0000_0200, ok);
    push_wr(10'h204, 32'h0000_0204, ok);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL mr_pre_req got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL mr_req got=%b exp=0", mem_req); end
    checks++; if (buf_empty !== 1'b1) begin failures++; $display("FAIL mr_empty got=%b exp=1", buf_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    auto_ack = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_req !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL mr_stale_req got=%b exp=1", quiet); end
    checks++; if (buf_empty !== 1'b1 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL mr_after got=%b%b exp=11", buf_empty, wr_ready);
    end
    checks++; if (log_addr.size() !== 0) begin failures++; $display("FAIL mr_log got=%0d exp=0", log_addr.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_full();
    test_drain_before_read();
    test_refill_empty();
    test_same_cycle();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
